gfx_rom_arbiter: RTL

//  Shares one external graphics-ROM read port (SDRAM bridge) among the three video fetchers: BG tile, TX tile, sprite gfx.

---
 rtl/gfx_arb_pkg.sv | 29 ++
 rtl/rr_pick3.sv | 37 +++
 rtl/gfx_rom_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/gfx_arb_pkg.sv
// gfx_arb_pkg: shared channel ids, FSM encodings and grant decode for the graphics-ROM arbiter.
// Rev 1.0
`default_nettype none
package gfx_arb_pkg;

  localparam int NCH = 3;

  typedef enum logic [1:0] {
    CH_BG = 2'd0,
    CH_TX = 2'd1,
    CH_SP = 2'd2
  } ch_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  function automatic ch_e oh2ch(input logic [NCH-1:0] oh);
    ch_e ch;
    ch = CH_BG;
    if (oh[CH_TX]) ch = CH_TX;
    if (oh[CH_SP]) ch = CH_SP;
    return ch;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick3.sv
// rr_pick3: three-way grant, sprite-first fixed priority or round-robin after the last memory-serviced channel.
// Rev 1.0
`default_nettype none
module rr_pick3
  import gfx_arb_pkg::*;
(
  input  logic [NCH-1:0] elig_i,
  input  ch_e            last_i,
  input  logic           sp_prio_i,
  output logic [NCH-1:0] grant_o
);

  function automatic logic [NCH-1:0] first3(input logic [NCH-1:0] e,
                                            input ch_e a, input ch_e b, input ch_e c);
    logic [NCH-1:0] r;
    r = '0;
    if (e[a])      r[a] = 1'b1;
    else if (e[b]) r[b] = 1'b1;
    else if (e[c]) r[c] = 1'b1;
    return r;
  endfunction

  always_comb begin
    grant_o = '0;
    if (sp_prio_i) begin
      grant_o = first3(elig_i, CH_SP, CH_BG, CH_TX);
    end else begin
      case (last_i)
        CH_TX:   grant_o = first3(elig_i, CH_SP, CH_BG, CH_TX);
        CH_SP:   grant_o = first3(elig_i, CH_BG, CH_TX, CH_SP);
        default: grant_o = first3(elig_i, CH_TX, CH_SP, CH_BG);
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/gfx_rom_arbiter.sv
// gfx_rom_arbiter: shares one graphics-ROM read port among BG/TX/sprite fetchers with a one-entry tag per channel.
// Rev 1.0
`default_nettype none
module gfx_rom_arbiter
  import gfx_arb_pkg::*;
#(
  parameter int AW = 17,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bg_req,
  input  logic [AW-1:0] bg_addr,
  output logic          bg_ack,
  output logic [DW-1:0] bg_data,
  input  logic          tx_req,
  input  logic [AW-1:0] tx_addr,
  output logic          tx_ack,
  output logic [DW-1:0] tx_data,
  input  logic          sp_req,
  input  logic [AW-1:0] sp_addr,
  output logic          sp_ack,
  output logic [DW-1:0] sp_data,
  input  logic          sp_prio,
  input  logic          flush,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ready,
  input  logic          mem_valid,
  input  logic [DW-1:0] mem_data
);

  state_e         state_q, state_d;
  ch_e            ch_q, ch_d;
  ch_e            last_q, last_d;
  logic           mem_req_q, mem_req_d;
  logic [AW-1:0]  mem_addr_q, mem_addr_d;
  logic [NCH-1:0] ack_q, ack_d;
  logic [NCH-1:0] tag_v_q, tag_v_d;
  logic [DW-1:0]  data_q  [NCH];
  logic [DW-1:0]  data_d  [NCH];
  logic [AW-1:0]  tag_a_q [NCH];
  logic [AW-1:0]  tag_a_d [NCH];
  logic [DW-1:0]  tag_d_q [NCH];
  logic [DW-1:0]  tag_d_d [NCH];

  logic [NCH-1:0] w_req, w_elig, w_grant;
  logic [AW-1:0]  w_addr [NCH];
  ch_e            w_gch;

  assign w_req     = {sp_req, tx_req, bg_req};
  assign w_addr[0] = bg_addr;
  assign w_addr[1] = tx_addr;
  assign w_addr[2] = sp_addr;
  // A channel whose ack is high this cycle may still show req; skip it to avoid a double service.
  assign w_elig    = w_req & ~ack_q;
  assign w_gch     = oh2ch(w_grant);

  rr_pick3 u_pick (
    .elig_i    (w_elig),
    .last_i    (last_q),
    .sp_prio_i (sp_prio),
    .grant_o   (w_grant)
  );

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    last_d     = last_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    ack_d      = '0;
    tag_v_d    = flush ? '0 : tag_v_q;
    data_d     = data_q;
    tag_a_d    = tag_a_q;
    tag_d_d    = tag_d_q;
    case (state_q)
      ST_IDLE: begin
        if (|w_grant) begin
          if (tag_v_q[w_gch] && (tag_a_q[w_gch] == w_addr[w_gch]) && !flush) begin
            data_d[w_gch] = tag_d_q[w_gch];
            ack_d[w_gch]  = 1'b1;
          end else begin
            ch_d       = w_gch;
            mem_addr_d = w_addr[w_gch];
            mem_req_d  = 1'b1;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_valid) begin
          data_d[ch_q]  = mem_data;
          tag_a_d[ch_q] = mem_addr_q;
          tag_d_d[ch_q] = mem_data;
          // A flush landing on the fill still delivers data but must not leave a valid tag.
          tag_v_d[ch_q] = !flush;
          ack_d[ch_q]   = 1'b1;
          last_d        = ch_q;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ch_q       <= CH_BG;
      last_q     <= CH_BG;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      ack_q      <= '0;
      tag_v_q    <= '0;
      for (int i = 0; i < NCH; i++) begin
        data_q[i]  <= '0;
        tag_a_q[i] <= '0;
        tag_d_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      last_q     <= last_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      ack_q      <= ack_d;
      tag_v_q    <= tag_v_d;
      data_q     <= data_d;
      tag_a_q    <= tag_a_d;
      tag_d_q    <= tag_d_d;
    end
  end

  assign bg_ack   = ack_q[0];
  assign tx_ack   = ack_q[1];
  assign sp_ack   = ack_q[2];
  assign bg_data  = data_q[0];
  assign tx_data  = data_q[1];
  assign sp_data  = data_q[2];
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule
`default_nettype wire
